// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: drives the req/ack data-memory port from EX/MEM,
// stalls upstream while an access is outstanding, resolves branches and
// registers each instruction's result (or a bubble) into MEM/WB.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_write_in,
  input  logic        mem_to_reg_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        branch_in,
  input  logic        zero_in,
  input  logic [31:0] branch_target_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] read_data2_in,
  input  logic [4:0]  write_reg_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] branch_target_out,
  output logic        reg_write_out,
  output logic        mem_to_reg_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  write_reg_out,
  output logic        misalign_out,
  output logic        bus_err_out
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next, cnt_inc;
  logic        op, aligned, access;
  logic        req_c, stall_c, abort, misalign_evt;

  assign op       = mem_read_in | mem_write_in;
  assign aligned  = (alu_result_in[1:0] == 2'b00);
  assign access   = op & aligned;
  // A misaligned op is rejected in IDLE without ever touching the bus.
  assign misalign_evt = (state == S_IDLE) & op & ~aligned;

  // Saturating wait counter; value after this WAIT cycle.
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  assign pc_src            = branch_in & zero_in;
  assign branch_target_out = branch_target_in;
  assign dmem_addr         = alu_result_in;
  assign dmem_wdata        = read_data2_in;
  // Reset must silence the bus and release the pipeline without a clock.
  assign dmem_req          = req_c & ~reset;
  assign stall             = stall_c & ~reset;
  // Write takes priority when both read and write are flagged.
  assign dmem_we           = dmem_req & mem_write_in;

  // State and wait-counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 16'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, request/stall and abort decode.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    req_c      = 1'b0;
    stall_c    = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE: begin
        if (access) begin
          req_c = 1'b1;
          if (!dmem_ack) begin
            stall_c    = 1'b1;
            state_next = S_WAIT;
            cnt_next   = 16'd0;
          end
        end
      end
      S_WAIT: begin
        cnt_next = cnt_inc;
        req_c    = 1'b1;
        if (dmem_ack) begin
          // Ack wins even in the cycle the timeout would fire.
          state_next = S_IDLE;
        end else if (cnt_inc >= TIMEOUT_W) begin
          req_c      = 1'b0;
          abort      = 1'b1;
          state_next = S_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // MEM/WB boundary: bubble on stall, otherwise retire the instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_out  <= 1'b0;
      mem_to_reg_out <= 1'b0;
      read_data_out  <= 32'd0;
      alu_result_out <= 32'd0;
      write_reg_out  <= 5'd0;
      misalign_out   <= 1'b0;
      bus_err_out    <= 1'b0;
    end else if (stall_c) begin
      reg_write_out  <= 1'b0;
      mem_to_reg_out <= 1'b0;
      write_reg_out  <= 5'd0;
      misalign_out   <= 1'b0;
      bus_err_out    <= 1'b0;
    end else begin
      write_reg_out  <= write_reg_in;
      alu_result_out <= alu_result_in;
      misalign_out   <= 1'b0;
      bus_err_out    <= 1'b0;
      if (abort) begin
        bus_err_out    <= 1'b1;
        reg_write_out  <= 1'b0;
        mem_to_reg_out <= 1'b0;
      end else if (misalign_evt) begin
        misalign_out   <= 1'b1;
        reg_write_out  <= 1'b0;
        mem_to_reg_out <= 1'b0;
      end else begin
        reg_write_out  <= reg_write_in;
        mem_to_reg_out <= mem_to_reg_in;
        if (access & mem_read_in & ~mem_write_in)
          read_data_out <= dmem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios followed by
// random instructions, checked against a per-instruction latency model.
module tb_mem_stage_ctrl;

  localparam int T     = 4;
  localparam int NOACK = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reg_write_in, mem_to_reg_in, mem_read_in, mem_write_in;
  logic        branch_in, zero_in;
  logic [31:0] branch_target_in, alu_result_in, read_data2_in;
  logic [4:0]  write_reg_in;
  logic        dmem_req, dmem_we, dmem_ack, stall, pc_src;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, branch_target_out;
  logic        reg_write_out, mem_to_reg_out, misalign_out, bus_err_out;
  logic [31:0] read_data_out, alu_result_out;
  logic [4:0]  write_reg_out;

  int vectors = 0;
  int miscompares = 0;

  // Expected MEM/WB contents.
  logic        e_rw = 0, e_m2r = 0, e_mis = 0, e_be = 0;
  logic [4:0]  e_wr = 0;
  logic [31:0] e_rd = 0, e_alu = 0;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .branch_in(branch_in), .zero_in(zero_in),
    .branch_target_in(branch_target_in), .alu_result_in(alu_result_in),
    .read_data2_in(read_data2_in), .write_reg_in(write_reg_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .pc_src(pc_src), .branch_target_out(branch_target_out),
    .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
    .read_data_out(read_data_out), .alu_result_out(alu_result_out),
    .write_reg_out(write_reg_out), .misalign_out(misalign_out),
    .bus_err_out(bus_err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string ctx);
    check({ctx, ".reg_write_out"},  32'(reg_write_out),  32'(e_rw));
    check({ctx, ".mem_to_reg_out"}, 32'(mem_to_reg_out), 32'(e_m2r));
    check({ctx, ".write_reg_out"},  32'(write_reg_out),  32'(e_wr));
    check({ctx, ".read_data_out"},  read_data_out,       e_rd);
    check({ctx, ".alu_result_out"}, alu_result_out,      e_alu);
    check({ctx, ".misalign_out"},   32'(misalign_out),   32'(e_mis));
    check({ctx, ".bus_err_out"},    32'(bus_err_out),    32'(e_be));
  endtask

  task automatic model_reset();
    e_rw = 0; e_m2r = 0; e_mis = 0; e_be = 0; e_wr = 0; e_rd = 0; e_alu = 0;
  endtask

  // One instruction held on EX/MEM until it retires. lat = cycles from the
  // request to the ack (0 = zero-wait); lat > T means the bus never answers.
  task automatic run_instr(input string name,
                           input logic rd, input logic wr, input logic br, input logic z,
                           input logic rw, input logic m2r,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] target, input logic [4:0] wreg,
                           input int lat, input logic [31:0] rdata);
    logic op, acc, e_req, e_stall;
    int   ncyc, nstall;
    op  = rd | wr;
    acc = op && (addr[1:0] == 2'b00);
    mem_read_in = rd; mem_write_in = wr; branch_in = br; zero_in = z;
    reg_write_in = rw; mem_to_reg_in = m2r; alu_result_in = addr;
    read_data2_in = wdata; branch_target_in = target; write_reg_in = wreg;
    if (!acc)         begin ncyc = 1;       nstall = 0;   end
    else if (lat <= T) begin ncyc = lat + 1; nstall = lat; end
    else              begin ncyc = T + 1;   nstall = T;   end
    for (int k = 0; k < ncyc; k++) begin
      e_req   = acc && (k < T || lat <= T);
      e_stall = (k < nstall);
      if (acc) begin
        dmem_ack   = (k == lat);
        dmem_rdata = (k == lat) ? rdata : $urandom();
      end else begin
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom();
      end
      #3;
      check({name, ".dmem_req"},   32'(dmem_req), 32'(e_req));
      check({name, ".dmem_we"},    32'(dmem_we),  32'(e_req & wr));
      check({name, ".stall"},      32'(stall),    32'(e_stall));
      check({name, ".pc_src"},     32'(pc_src),   32'(br & z));
      check({name, ".target"},     branch_target_out, target);
      check({name, ".dmem_addr"},  dmem_addr,  addr);
      check({name, ".dmem_wdata"}, dmem_wdata, wdata);
      @(posedge clk); #1;
      if (e_stall) begin
        e_rw = 0; e_m2r = 0; e_wr = 0; e_mis = 0; e_be = 0;
      end else begin
        e_wr = wreg; e_alu = addr; e_mis = 0; e_be = 0;
        if (op && !acc) begin
          e_mis = 1; e_rw = 0; e_m2r = 0;
        end else if (acc && lat > T) begin
          e_be = 1; e_rw = 0; e_m2r = 0;
        end else begin
          e_rw = rw; e_m2r = m2r;
          if (acc && rd && !wr) e_rd = rdata;
        end
      end
      check_regs(name);
    end
  endtask

  initial begin
    reg_write_in = 0; mem_to_reg_in = 0; mem_read_in = 0; mem_write_in = 0;
    branch_in = 0; zero_in = 0; branch_target_in = 0; alu_result_in = 0;
    read_data2_in = 0; write_reg_in = 0; dmem_ack = 0; dmem_rdata = 0;

    // Reset state.
    @(posedge clk); #1;
    check("reset.dmem_req", 32'(dmem_req), 32'd0);
    check("reset.stall",    32'(stall),    32'd0);
    model_reset();
    check_regs("reset");
    reset = 1'b0;

    // Directed scenarios.
    run_instr("zw_load",   1, 0, 0, 0, 1, 1, 32'h10, 32'h0,    32'h0,   5'd5, 0, 32'hDEADBEEF);
    run_instr("store3",    0, 1, 0, 0, 0, 0, 32'h20, 32'h1234, 32'h0,   5'd0, 3, 32'h0);
    run_instr("misalign",  1, 0, 0, 0, 1, 1, 32'h22, 32'h0,    32'h0,   5'd7, 0, 32'h55AA55AA);
    run_instr("timeout",   1, 0, 0, 0, 1, 1, 32'h30, 32'h0,    32'h0,   5'd9, NOACK, 32'h0);
    run_instr("ack_at_to", 1, 0, 0, 0, 1, 1, 32'h34, 32'h0,    32'h0,   5'd9, T, 32'hCAFEF00D);
    run_instr("rw_both",   1, 1, 0, 0, 0, 0, 32'h38, 32'hABCD, 32'h0,   5'd3, 1, 32'h11111111);
    run_instr("br_taken",  0, 0, 1, 1, 0, 0, 32'h0,  32'h0,    32'h400, 5'd0, 0, 32'h0);
    run_instr("br_not",    0, 0, 1, 0, 0, 0, 32'h0,  32'h0,    32'h400, 5'd0, 0, 32'h0);
    run_instr("alu_op",    0, 0, 0, 0, 1, 0, 32'h77, 32'h0,    32'h0,   5'd12, 0, 32'h0);

    // Reset in the second WAIT cycle.
    mem_read_in = 1; mem_write_in = 0; reg_write_in = 1; mem_to_reg_in = 1;
    alu_result_in = 32'h40; write_reg_in = 5'd4; dmem_ack = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    check("rst_wait.req_before",   32'(dmem_req), 32'd1);
    check("rst_wait.stall_before", 32'(stall),    32'd1);
    reset = 1'b1;
    #1;
    check("rst_wait.dmem_req", 32'(dmem_req), 32'd0);
    check("rst_wait.stall",    32'(stall),    32'd0);
    check("rst_wait.dmem_we",  32'(dmem_we),  32'd0);
    model_reset();
    check_regs("rst_wait");
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr("post_rst", 1, 0, 0, 0, 1, 1, 32'h44, 32'h0, 32'h0, 5'd6, 2, 32'h0BADF00D);

    // Random instruction stream.
    for (int n = 0; n < 200; n++) begin
      logic rd, wr, br, z, rw, m2r;
      logic [31:0] addr;
      int sel;
      sel  = $urandom_range(0, 2);
      rd   = (sel == 1) || ($urandom_range(0, 7) == 0 && sel == 2);
      wr   = (sel == 2);
      br   = 1'($urandom_range(0, 1));
      z    = 1'($urandom_range(0, 1));
      rw   = 1'($urandom_range(0, 1));
      m2r  = 1'($urandom_range(0, 1));
      addr = $urandom();
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      run_instr("rand", rd, wr, br, z, rw, m2r, addr, $urandom(), $urandom(),
                5'($urandom_range(0, 31)), $urandom_range(0, T + 2), $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
